relm_hex_push: RTL and testbench

- Parametrised seven-segment display peripheral on one ReLM push channel.
- Generalises the fixed 4-digit static hex writer to NDIG digits, optional time-multiplexed scanning, hex nibble decode and per-digit blink.
- Uses shadow/commit double buffering so the display never tears mid-frame.
- Backpressures the core through retry_out.

---
 rtl/relm_hex_push_if.sv | 10 +
 rtl/relm_hex_push.sv | 140 ++++++++++++++
 tb/tb_relm_hex_push.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/relm_hex_push_if.sv
// ReLM push channel: the core drives a strobed push word, the peripheral answers with retry.
interface relm_hex_push_if #(
    parameter int WD = 32
);
    logic [WD:0] push_in;
    logic        retry_out;

    modport master (output push_in, input retry_out);
    modport slave  (input push_in, output retry_out);
endinterface

// File: rtl/relm_hex_push.sv
// Seven-segment display peripheral on a ReLM push channel: banked shadow writes, frame-aligned
// commit into display registers, static or scanned output, optional hex decode and blink.
module relm_hex_push #(
    parameter int WD          = 32,
    parameter int NDIG        = 4,
    parameter int MODE        = 0,
    parameter int DECODE      = 0,
    parameter int WSCAN       = 10,
    parameter int WBLINK      = 24,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    relm_hex_push_if.slave     bus,
    output logic [7*NDIG-1:0]  seg_out,
    output logic [6:0]         scan_seg_out,
    output logic [NDIG-1:0]    scan_dig_out
);
    localparam int NB = (NDIG + 3) / 4;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
        endcase
    endfunction

    // Digits are stored as {blink, lit segments}, so an all-zero register is dark in either mode.
    function automatic logic [7:0] encode(input logic [6:0] d);
        if (DECODE != 0) encode = {d[5], d[4] ? 7'h00 : hex7(d[3:0])};
        else             encode = {1'b0, d};
    endfunction

    logic [BW-1:0]     bank_reg;
    logic [NB-1:0]     pending_reg;
    logic [WSCAN-1:0]  scan_cnt_reg;
    logic [IW-1:0]     idx_reg;
    logic [WBLINK-1:0] blink_cnt_reg;
    logic [3:0]        en;
    logic [NB-1:0]     bank_onehot;
    logic [NB-1:0]     set_mask;
    logic [NDIG-1:0]   idx_onehot;
    logic [6:0]        lit [NDIG];
    logic [6:0]        scan_lit;
    logic [7*NDIG-1:0] seg_next;
    logic              strobe, any_en, pend_cur, accept, sync_word, commit, blink_on, slot_last;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_en
        assign en[gi] = bus.push_in[8*gi];
    end

    assign strobe        = bus.push_in[WD];
    assign any_en        = |en;
    assign bank_onehot   = NB'(1) << bank_reg;
    assign pend_cur      = |(pending_reg & bank_onehot);
    assign bus.retry_out = strobe & any_en & pend_cur;
    assign accept        = strobe & any_en & ~pend_cur;
    assign sync_word     = strobe & ~any_en;
    assign set_mask      = accept ? bank_onehot : '0;
    assign blink_on      = blink_cnt_reg[WBLINK-1];
    assign slot_last     = &scan_cnt_reg;
    assign commit        = (MODE == 0) ? 1'b1 : (slot_last && idx_reg == IW'(NDIG-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_reg      <= '0;
            pending_reg   <= '0;
            scan_cnt_reg  <= '0;
            idx_reg       <= '0;
            blink_cnt_reg <= '0;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
            scan_cnt_reg  <= scan_cnt_reg + 1'b1;
            if (slot_last)
                idx_reg <= (idx_reg == IW'(NDIG-1)) ? '0 : idx_reg + 1'b1;
            // Commit drains every pending bank; a same-cycle accept re-arms its own bank.
            pending_reg <= (commit ? '0 : pending_reg) | set_mask;
            if (accept)
                bank_reg <= (bank_reg == BW'(NB-1)) ? '0 : bank_reg + 1'b1;
            else if (sync_word)
                bank_reg <= '0;
        end
    end

    for (gi = 0; gi < NDIG; gi++) begin : g_dig
        localparam int B = gi / 4;
        localparam int S = gi % 4;
        logic [7:0] shadow_reg;
        logic [7:0] disp_reg;
        logic       wr;

        assign wr = accept && en[S] && (bank_reg == BW'(B));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg <= '0;
                disp_reg   <= '0;
            end else begin
                if (commit && pending_reg[B]) disp_reg <= shadow_reg;
                if (wr) shadow_reg <= encode(bus.push_in[8*S+1 +: 7]);
            end
        end

        assign lit[gi] = (disp_reg[7] && blink_on) ? 7'h00 : disp_reg[6:0];
        assign seg_next[7*gi +: 7] = (MODE == 0) ? ~lit[gi] : 7'h7F;
    end

    always_comb begin
        scan_lit = 7'h00;
        for (int i = 0; i < NDIG; i++)
            if (idx_reg == IW'(i)) scan_lit = lit[i];
    end

    assign idx_onehot = NDIG'(1) << idx_reg;

    // Slot cycle 0 drives every select inactive so the previous digit cannot ghost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out      <= '1;
            scan_seg_out <= '1;
            scan_dig_out <= DIG_OFF;
        end else begin
            seg_out <= seg_next;
            if (MODE == 0 || scan_cnt_reg == '0) begin
                scan_seg_out <= '1;
                scan_dig_out <= DIG_OFF;
            end else begin
                scan_seg_out <= ~scan_lit;
                scan_dig_out <= idx_onehot ^ DIG_OFF;
            end
        end
    end
endmodule

// File: tb/tb_relm_hex_push.sv
// Scoreboard bench: a static decode instance and a scanned raw instance, both with six digits,
// checked each cycle against a digit-level model of banks, pending flags and frame commits.
module tb_relm_hex_push;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    relm_hex_push_if #(.WD(32)) bus0 ();
    relm_hex_push_if #(.WD(32)) bus1 ();

    logic [41:0] seg0, seg1;
    logic [6:0]  sseg0, sseg1;
    logic [5:0]  sdig0, sdig1;

    relm_hex_push #(.WD(32), .NDIG(6), .MODE(0), .DECODE(1), .WSCAN(4), .WBLINK(4), .DIG_ACT_LOW(1)) u0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .seg_out(seg0), .scan_seg_out(sseg0), .scan_dig_out(sdig0));

    relm_hex_push #(.WD(32), .NDIG(6), .MODE(1), .DECODE(0), .WSCAN(4), .WBLINK(4), .DIG_ACT_LOW(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .seg_out(seg1), .scan_seg_out(sseg1), .scan_dig_out(sdig1));

    typedef struct {
        int          stamp;
        logic [41:0] seg0;
        logic [12:0] scan0;
        logic [41:0] seg1;
        logic [12:0] scan1;
    } out_t;
    typedef struct {
        int   stamp;
        logic r0;
        logic r1;
    } rty_t;

    out_t oq[$];
    rty_t rq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Clock edges seen since reset was last released; cycle k's outputs land after edge k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: per DUT, bank pointer, pending banks, shadow and displayed digit {blink, lit}.
    int         m_bank   [2];
    bit         m_pend   [2][2];
    logic [7:0] m_shadow [2][6];
    logic [7:0] m_disp   [2][6];

    function automatic logic [7:0] enc(input int d, input logic [6:0] v);
        if (d == 0) return {v[5], v[4] ? 7'h00 : HEX[v[3:0]]};
        return {1'b0, v};
    endfunction

    // Blink phase is bit 3 of the clocks counted since reset before the output edge.
    function automatic logic [6:0] shown(input logic [7:0] v, input int k);
        bit ph;
        ph = ((k - 1) & 8) != 0;
        return (v[7] && ph) ? 7'h00 : v[6:0];
    endfunction

    function automatic logic [32:0] rnd_word();
        logic [31:0] v;
        bit          s;
        v = $urandom;
        s = ($urandom_range(0, 3) != 0);
        return {s, v};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_bank[d] = 0;
            for (int b = 0; b < 2; b++) m_pend[d][b] = 1'b0;
            for (int i = 0; i < 6; i++) begin
                m_shadow[d][i] = 8'h00;
                m_disp[d][i]   = 8'h00;
            end
        end
    endtask

    task automatic push_reset_record();
        out_t o;
        o.stamp = 0;
        o.seg0  = '1;
        o.scan0 = '1;
        o.seg1  = '1;
        o.scan1 = '1;
        oq.push_back(o);
        rq.push_back('{0, 1'b0, 1'b0});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of pushes, queue the expected responses, then advance the model by one edge.
    task automatic step(input logic [32:0] w0, input logic [32:0] w1, output bit rt0, output bit rt1);
        logic [32:0] w [2];
        bit          r [2];
        bit          any_en, commit;
        int          k, p, idx, bk;
        out_t        o;
        w[0] = w0;
        w[1] = w1;
        bus0.push_in = w0;
        bus1.push_in = w1;
        k = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            any_en = w[d][0] | w[d][8] | w[d][16] | w[d][24];
            r[d]   = w[d][32] && any_en && m_pend[d][m_bank[d]];
        end
        rq.push_back('{cyc, r[0], r[1]});

        o.stamp = k;
        for (int i = 0; i < 6; i++) o.seg0[7*i +: 7] = ~shown(m_disp[0][i], k);
        o.scan0 = '1;
        o.seg1  = '1;
        p   = (k - 1) % 96;
        idx = p / 16;
        if (p % 16 == 0) o.scan1 = '1;
        else             o.scan1 = {~shown(m_disp[1][idx], k), ~(6'b1 << idx)};
        oq.push_back(o);

        for (int d = 0; d < 2; d++) begin
            any_en = w[d][0] | w[d][8] | w[d][16] | w[d][24];
            commit = (d == 0) || ((k - 1) % 96 == 95);
            if (commit) begin
                for (int b = 0; b < 2; b++) begin
                    if (m_pend[d][b]) begin
                        for (int j = 0; j < 4; j++)
                            if (4*b + j < 6) m_disp[d][4*b + j] = m_shadow[d][4*b + j];
                        m_pend[d][b] = 1'b0;
                    end
                end
            end
            if (w[d][32] && any_en && !r[d]) begin
                bk = m_bank[d];
                for (int j = 0; j < 4; j++)
                    if (w[d][8*j] && 4*bk + j < 6) m_shadow[d][4*bk + j] = enc(d, w[d][8*j+1 +: 7]);
                m_pend[d][bk] = 1'b1;
                m_bank[d] = (bk + 1) % 2;
                $display("push dut%0d edge=%0d bank=%0d word=%h", d, k, bk, w[d]);
            end else if (w[d][32] && !any_en) begin
                m_bank[d] = 0;
            end
        end
        rt0 = r[0];
        rt1 = r[1];
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [32:0] w);
        bit a, b;
        b = 1'b1;
        for (int n = 0; n < 200 && b; n++) step(33'h0, w, a, b);
    endtask

    always @(negedge clk) begin
        rty_t t;
        out_t o;
        if (rq.size() > 0 && rq[0].stamp == cyc) begin
            t = rq.pop_front();
            chk("retry0", 64'(bus0.retry_out), 64'(t.r0));
            chk("retry1", 64'(bus1.retry_out), 64'(t.r1));
        end
        if (oq.size() > 0 && oq[0].stamp == cyc) begin
            o = oq.pop_front();
            chk("static_seg", 64'(seg0), 64'(o.seg0));
            chk("static_scan_idle", 64'({sseg0, sdig0}), 64'(o.scan0));
            chk("scan_seg_idle", 64'(seg1), 64'(o.seg1));
            chk("scan_out", 64'({sseg1, sdig1}), 64'(o.scan1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r0, r1;
        logic [32:0] c0, c1;
        bus0.push_in = '0;
        bus1.push_in = '0;
        model_reset();
        push_reset_record();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Static decode: bank0 nibbles 0..3, bank1 nibbles A/F, sync, bank0 again with a blinking digit 2.
        step(33'h1_07050301, 33'h0, r0, r1);
        step(33'h1_00001F15, 33'h0, r0, r1);
        step(33'h1_00000000, 33'h0, r0, r1);
        step(33'h1_0F4D0B09, 33'h0, r0, r1);
        repeat (40) step(33'h0, 33'h0, r0, r1);

        // Scanned raw: bank0, bank1 (upper slots ignored), bank0 again retried until the frame commit.
        send1(33'h1_CD9FB70D);
        send1(33'h1_55AAE711);
        send1(33'h1_7F3B2981);
        repeat (110) step(33'h0, 33'h0, r0, r1);

        c0 = rnd_word();
        c1 = rnd_word();
        for (int n = 0; n < 400; n++) begin
            step(c0, c1, r0, r1);
            if (!r0) c0 = rnd_word();
            if (!r1) c1 = rnd_word();
        end

        // Reset mid-frame while banks 0 and 1 are pending on the scanned instance.
        step(33'h0, 33'h1_00000000, r0, r1);
        send1(33'h1_0B0D0F11);
        send1(33'h1_00002113);
        rst = 1'b1;
        oq.delete();
        rq.delete();
        model_reset();
        bus0.push_in = 33'h1_07050301;
        bus1.push_in = 33'h1_7F3B2981;
        push_reset_record();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(33'h1_07050301, 33'h1_7F3B2981, r0, r1);
        repeat (120) step(33'h0, 33'h0, r0, r1);

        repeat (2) @(negedge clk);
        total++;
        if (oq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked records expected 0", oq.size() + rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
